// File: rtl/cla_pipe_add32.sv
// Two-stage pipelined 32-bit adder built from two CLA_16bit slices, with valid/ready flow control.
// Optional subtract mode is compiled in when CLA_PIPE_SUB_EN is defined (adds the `sub` input).

module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        G,
  output logic        P
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [3:0]  w_cg;
  logic [3:0]  w_gs;
  logic [3:0]  w_ps;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Two-level lookahead: 4-bit group G/P first, then group carries, then bit carries.
  always_comb begin
    w_gg = '0;
    w_gp = '0;
    w_cg = '0;
    w_c  = '0;
    w_gs = '0;
    w_ps = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_gs    = w_g[4*k +: 4];
      w_ps    = w_p[4*k +: 4];
      w_gg[k] = w_gs[3]
              | (w_ps[3] & w_gs[2])
              | (w_ps[3] & w_ps[2] & w_gs[1])
              | (w_ps[3] & w_ps[2] & w_ps[1] & w_gs[0]);
      w_gp[k] = &w_ps;
    end

    w_cg[0] = cin;
    w_cg[1] = w_gg[0] | (w_gp[0] & cin);
    w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
    w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & cin);

    for (int unsigned k = 0; k < 4; k++) begin
      w_gs = w_g[4*k +: 4];
      w_ps = w_p[4*k +: 4];
      w_c[4*k]     = w_cg[k];
      w_c[4*k + 1] = w_gs[0] | (w_ps[0] & w_cg[k]);
      w_c[4*k + 2] = w_gs[1] | (w_ps[1] & w_gs[0]) | (w_ps[1] & w_ps[0] & w_cg[k]);
      w_c[4*k + 3] = w_gs[2] | (w_ps[2] & w_gs[1]) | (w_ps[2] & w_ps[1] & w_gs[0])
                   | (w_ps[2] & w_ps[1] & w_ps[0] & w_cg[k]);
    end
  end

  assign sum = w_p ^ w_c;
  assign G   = w_gg[3]
             | (w_gp[3] & w_gg[2])
             | (w_gp[3] & w_gp[2] & w_gg[1])
             | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
  assign P   = &w_gp;

endmodule

module cla_pipe_add32 #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  logic [31:0]      w_b_eff;
  logic             w_cin_eff;
  logic             w_adv2;
  logic             w_in_xfer;
  logic [15:0]      w_lo_sum;
  logic             w_lo_G;
  logic             w_lo_P;
  logic [15:0]      w_hi_sum;
  logic             w_hi_G;
  logic             w_hi_P;

  logic             r_s1_valid;
  logic [15:0]      r_s1_sum_lo;
  logic             r_s1_c16;
  logic [15:0]      r_s1_a_hi;
  logic [15:0]      r_s1_b_hi;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_out_valid;
  logic [31:0]      r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [TAG_W-1:0] r_out_tag;

`ifdef CLA_PIPE_SUB_EN
  // Subtraction as a + ~b + 1; the inverted high operand is what stage 1 stores,
  // so stage 2 and the overflow term need no knowledge of the mode.
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : cin;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = cin;
`endif

  assign w_adv2    = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_adv2;
  assign w_in_xfer = in_valid && in_ready;

  CLA_16bit u_cla_lo (
    .a   (a[15:0]),
    .b   (w_b_eff[15:0]),
    .cin (w_cin_eff),
    .sum (w_lo_sum),
    .G   (w_lo_G),
    .P   (w_lo_P)
  );

  CLA_16bit u_cla_hi (
    .a   (r_s1_a_hi),
    .b   (r_s1_b_hi),
    .cin (r_s1_c16),
    .sum (w_hi_sum),
    .G   (w_hi_G),
    .P   (w_hi_P)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sum_lo <= '0;
      r_s1_c16    <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
      r_s1_tag    <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid  <= 1'b1;
      r_s1_sum_lo <= w_lo_sum;
      r_s1_c16    <= w_lo_G | (w_lo_P & w_cin_eff);
      r_s1_a_hi   <= a[31:16];
      r_s1_b_hi   <= w_b_eff[31:16];
      r_s1_tag    <= in_tag;
    end else if (w_adv2) begin
      r_s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_tag   <= '0;
    end else if (r_s1_valid && w_adv2) begin
      r_out_valid <= 1'b1;
      r_sum       <= {w_hi_sum, r_s1_sum_lo};
      r_cout      <= w_hi_G | (w_hi_P & r_s1_c16);
      r_ovf       <= (r_s1_a_hi[15] == r_s1_b_hi[15]) && (w_hi_sum[15] != r_s1_a_hi[15]);
      r_out_tag   <= r_s1_tag;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_cla_pipe_add32.sv
// Directed self-checking bench for cla_pipe_add32 (subtract vectors run when CLA_PIPE_SUB_EN is defined).

module tb_cla_pipe_add32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic [3:0]  out_tag;

  int errors = 0;
  int checks = 0;

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic        sc [8];
  logic [32:0] wide;
  logic [31:0] es;
  logic        eo;

  always #5 clk = ~clk;

  cla_pipe_add32 #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_PIPE_SUB_EN
    .sub       (sub),
`endif
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_tag   (out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one beat into an empty pipeline and check the result two cycles later.
  task automatic send_one(input string nm, input logic [31:0] va, input logic [31:0] vb,
                          input logic vc, input logic vs, input logic [3:0] vt,
                          input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    a = va; b = vb; cin = vc; sub = vs; in_tag = vt; in_valid = 1'b1; out_ready = 1'b1;
    chk({nm, "_in_ready"}, 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    chk({nm, "_not_yet_valid"}, 64'(out_valid), 64'(0));
    step();
    chk({nm, "_out_valid"}, 64'(out_valid), 64'(1));
    chk({nm, "_sum"}, 64'(sum), 64'(exp_sum));
    chk({nm, "_cout"}, 64'(cout), 64'(exp_cout));
    chk({nm, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    chk({nm, "_tag"}, 64'(out_tag), 64'(vt));
    step();
    chk({nm, "_drained"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_tag", 64'(out_tag), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    send_one("c16", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 4'h1, 32'h00010000, 1'b0, 1'b0);
    send_one("wrap", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'h2, 32'h00000000, 1'b1, 1'b0);
    send_one("ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h3, 32'h80000000, 1'b0, 1'b1);

    // Streaming: eight back-to-back beats with out_ready held high.
    sa[0] = 32'h12345678; sb[0] = 32'h87654321; sc[0] = 1'b0;
    sa[1] = 32'hFFFF0000; sb[1] = 32'h00010000; sc[1] = 1'b0;
    sa[2] = 32'h0000FFFF; sb[2] = 32'h0000FFFF; sc[2] = 1'b1;
    sa[3] = 32'h80000000; sb[3] = 32'h80000000; sc[3] = 1'b0;
    sa[4] = 32'h7FFFFFFF; sb[4] = 32'h7FFFFFFF; sc[4] = 1'b0;
    sa[5] = 32'hDEADBEEF; sb[5] = 32'h01234567; sc[5] = 1'b1;
    sa[6] = 32'h00000000; sb[6] = 32'h00000000; sc[6] = 1'b1;
    sa[7] = 32'hAAAAAAAA; sb[7] = 32'h55555555; sc[7] = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        a = sa[c]; b = sb[c]; cin = sc[c]; in_tag = 4'(c); in_valid = 1'b1;
        chk($sformatf("stream_in_ready_%0d", c), 64'(in_ready), 64'(1));
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 1 && c <= 8) begin
        wide = {1'b0, sa[c-1]} + {1'b0, sb[c-1]} + 33'(sc[c-1]);
        eo   = (sa[c-1][31] == sb[c-1][31]) && (wide[31] != sa[c-1][31]);
        chk($sformatf("stream_valid_%0d", c-1), 64'(out_valid), 64'(1));
        chk($sformatf("stream_sum_%0d", c-1), 64'(sum), 64'(wide[31:0]));
        chk($sformatf("stream_cout_%0d", c-1), 64'(cout), 64'(wide[32]));
        chk($sformatf("stream_ovf_%0d", c-1), 64'(ovf), 64'(eo));
        chk($sformatf("stream_tag_%0d", c-1), 64'(out_tag), 64'(c-1));
      end
    end
    chk("stream_drained", 64'(out_valid), 64'(0));

    // Backpressure: beats X, Y, Z with out_ready low.
    out_ready = 1'b0;
    a = 32'h00000010; b = 32'h00000001; cin = 1'b0; in_tag = 4'hA; in_valid = 1'b1;
    chk("bp_x_ready", 64'(in_ready), 64'(1));
    step();
    a = 32'h00000020; b = 32'h00000002; in_tag = 4'hB;
    chk("bp_y_ready", 64'(in_ready), 64'(1));
    step();
    a = 32'h00000030; b = 32'h00000003; in_tag = 4'hC;
    chk("bp_z_blocked", 64'(in_ready), 64'(0));
    chk("bp_x_valid", 64'(out_valid), 64'(1));
    chk("bp_x_sum", 64'(sum), 64'(32'h11));
    chk("bp_x_tag", 64'(out_tag), 64'(4'hA));
    step();
    step();
    chk("bp_hold_valid", 64'(out_valid), 64'(1));
    chk("bp_hold_sum", 64'(sum), 64'(32'h11));
    chk("bp_hold_tag", 64'(out_tag), 64'(4'hA));
    chk("bp_hold_blocked", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    chk("bp_y_sum", 64'(sum), 64'(32'h22));
    chk("bp_y_tag", 64'(out_tag), 64'(4'hB));
    step();
    chk("bp_z_valid", 64'(out_valid), 64'(1));
    chk("bp_z_sum", 64'(sum), 64'(32'h33));
    chk("bp_z_tag", 64'(out_tag), 64'(4'hC));
    step();
    chk("bp_drained", 64'(out_valid), 64'(0));

    // Reset with both stages full.
    out_ready = 1'b0;
    a = 32'h1; b = 32'h1; in_tag = 4'h5; in_valid = 1'b1;
    step();
    a = 32'h2; b = 32'h2; in_tag = 4'h6;
    step();
    in_valid = 1'b0;
    chk("full_before_reset", 64'(in_ready), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", 64'(out_valid), 64'(0));
    send_one("after_rst", 32'h00000005, 32'h00000007, 1'b0, 1'b0, 4'h7, 32'h0000000C, 1'b0, 1'b0);

`ifdef CLA_PIPE_SUB_EN
    send_one("sub_neg", 32'h00000003, 32'h00000005, 1'b0, 1'b1, 4'h8, 32'hFFFFFFFE, 1'b0, 1'b0);
    send_one("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'h9, 32'h7FFFFFFF, 1'b1, 1'b1);
    send_one("sub_cin_ign", 32'h00000009, 32'h00000004, 1'b0, 1'b1, 4'hD, 32'h00000005, 1'b1, 1'b0);
`endif

    es = 32'h0;
    if (es != 32'h0) $display("unreachable");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
